// File: rtl/enable_tick_gen_pkg.sv
// enable_tick_gen shared definitions:
// FSM state encoding and divide-ratio clamp.
package enable_tick_gen_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int unsigned DIV_CLAMP = 1;

endpackage

// File: rtl/enable_tick_gen_prescaler.sv
// Tick prescaler: counts clocks between ticks
// and flags the terminal count (div_q - 1).
module tick_prescaler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [DIV_WIDTH-1:0] div_q,
  output logic                 terminal
);

  logic [DIV_WIDTH-1:0] cnt;

  assign terminal = (cnt == div_q - DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= terminal ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/enable_tick_gen.sv
// Programmable-rate enable tick generator with
// start/stop/hold control and optional burst length.
module enable_tick_gen
  import enable_tick_gen_defs::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_hold,
  input  logic [DIV_WIDTH-1:0]   i_div,
  input  logic [BURST_WIDTH-1:0] i_burst,
  output logic                   o_enable,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [BURST_WIDTH-1:0] o_tick_count
);

  state_t state, state_nxt;

  logic [DIV_WIDTH-1:0]   div_q;
  logic [BURST_WIDTH-1:0] burst_q;
  logic [BURST_WIDTH-1:0] cnt_nxt;
  logic active, go, adv, term, fire, last;

  assign active  = (state == ST_RUN) || (state == ST_HOLD);
  assign go      = (state == ST_IDLE) && i_start && !i_stop;
  assign adv     = active && !i_stop && !i_hold;
  assign fire    = adv && term;
  assign cnt_nxt = o_tick_count + BURST_WIDTH'(1);
  assign last    = fire && (burst_q != '0)
                 && (cnt_nxt == burst_q);

  tick_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_presc (
    .clk      (clk),
    .reset    (reset),
    .clear    (go),
    .advance  (adv),
    .div_q    (div_q),
    .terminal (term)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nxt = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        unique case (1'b1)
          i_stop:             state_nxt = ST_IDLE;
          (i_hold && !i_stop): state_nxt = ST_HOLD;
          last:               state_nxt = ST_IDLE;
          default:            state_nxt = ST_RUN;
        endcase
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy trails the state by one cycle so it
  // rises the edge after start and falls the
  // edge after the final tick or stop
  always_ff @(posedge clk) begin
    if (reset) begin
      o_enable     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_tick_count <= '0;
      div_q        <= DIV_WIDTH'(DIV_CLAMP);
      burst_q      <= '0;
    end else begin
      o_enable <= fire;
      o_busy   <= active;
      o_done   <= last;
      if (go) begin
        div_q        <= (i_div == '0)
                      ? DIV_WIDTH'(DIV_CLAMP) : i_div;
        burst_q      <= i_burst;
        o_tick_count <= '0;
      end else if (fire) begin
        o_tick_count <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_enable_tick_gen.sv
// Self-checking bench for enable_tick_gen:
// expected tick/done cycles queued at stimulus time.
module tb_enable_tick_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start, i_stop, i_hold;
  logic [15:0] i_div, i_burst;
  logic        o_enable, o_busy, o_done;
  logic [15:0] o_tick_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_q[$];
  int done_q[$];
  logic [7:0] cnt8 = 8'h00;
  int wraps = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  enable_tick_gen #(
    .DIV_WIDTH   (16),
    .BURST_WIDTH (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_hold       (i_hold),
    .i_div        (i_div),
    .i_burst      (i_burst),
    .o_enable     (o_enable),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tick_count (o_tick_count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // scoreboard monitor; also models the chained 8-bit counter
  always @(negedge clk) begin
    int e;
    if (o_enable) begin
      e = -1;
      if (en_q.size() > 0) e = en_q.pop_front();
      check("tick_at", cyc, e);
      if (cnt8 == 8'hFF) wraps++;
      cnt8++;
    end
    if (o_done) begin
      e = -1;
      if (done_q.size() > 0) e = done_q.pop_front();
      check("done_at", cyc, e);
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic run_burst(input int div, input int burst);
    int k, d;
    d = (div == 0) ? 1 : div;
    @(negedge clk);
    i_div = 16'(div);
    i_burst = 16'(burst);
    i_start = 1'b1;
    k = cyc + 1;
    for (int i = 1; i <= burst; i++) en_q.push_back(k + d * i);
    done_q.push_back(k + d * burst);
    @(negedge clk);
    i_start = 1'b0;
    check("busy_k", o_busy, 0);
    @(negedge clk);
    check("busy_k1", o_busy, 1);
    i_start = 1'b1;
    i_div = 16'd7;
    @(negedge clk);
    i_start = 1'b0;
    wait_to(k + d * burst);
    check("busy_last", o_busy, 1);
    check("cnt_last", o_tick_count, burst);
    @(negedge clk);
    check("busy_end", o_busy, 0);
    check("q_empty", en_q.size() + done_q.size(), 0);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    i_start = 1'b0;
    i_stop = 1'b0;
    i_hold = 1'b0;
    i_div = 16'd0;
    i_burst = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_en", o_enable, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_cnt", o_tick_count, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // finite burst: div 4, three ticks
    run_burst(4, 3);

    // div 0 continuous, stop after 10 ticks
    @(negedge clk);
    i_div = 16'd0;
    i_burst = 16'd0;
    i_start = 1'b1;
    k = cyc + 1;
    for (int i = 1; i <= 10; i++) en_q.push_back(k + i);
    @(negedge clk);
    i_start = 1'b0;
    wait_to(k + 10);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    check("c_en_off", o_enable, 0);
    check("c_cnt", o_tick_count, 10);
    @(negedge clk);
    check("c_busy", o_busy, 0);
    check("c_cnt_hold", o_tick_count, 10);

    // hold for 7 cycles after second tick
    @(negedge clk);
    i_div = 16'd5;
    i_burst = 16'd0;
    i_start = 1'b1;
    k = cyc + 1;
    en_q.push_back(k + 5);
    en_q.push_back(k + 10);
    en_q.push_back(k + 22);
    en_q.push_back(k + 27);
    @(negedge clk);
    i_start = 1'b0;
    wait_to(k + 10);
    i_hold = 1'b1;
    wait_to(k + 17);
    check("h_busy", o_busy, 1);
    check("h_cnt", o_tick_count, 2);
    i_hold = 1'b0;
    wait_to(k + 27);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    @(negedge clk);
    check("h_cnt_end", o_tick_count, 4);

    // start and stop together in idle: stay idle
    i_start = 1'b1;
    i_stop = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_stop = 1'b0;
    repeat (3) @(negedge clk);
    check("ss_busy", o_busy, 0);
    check("ss_cnt", o_tick_count, 4);

    // stop on terminal count, div changed mid-run
    @(negedge clk);
    i_div = 16'd4;
    i_burst = 16'd0;
    i_start = 1'b1;
    k = cyc + 1;
    en_q.push_back(k + 4);
    en_q.push_back(k + 8);
    @(negedge clk);
    i_start = 1'b0;
    i_div = 16'd2;
    wait_to(k + 11);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    check("st_en", o_enable, 0);
    check("st_done", o_done, 0);
    @(negedge clk);
    check("st_busy", o_busy, 0);
    check("st_cnt", o_tick_count, 2);
    repeat (6) @(negedge clk);
    check("st_q", en_q.size(), 0);

    // chained 8-bit counter, 300 ticks at div 2
    cnt8 = 8'h00;
    wraps = 0;
    run_burst(2, 300);
    check("ch_val", cnt8, 8'h2C);
    check("ch_wraps", wraps, 1);

    // reset mid-burst, then restart as from power-up
    @(negedge clk);
    i_div = 16'd3;
    i_burst = 16'd5;
    i_start = 1'b1;
    k = cyc + 1;
    en_q.push_back(k + 3);
    en_q.push_back(k + 6);
    @(negedge clk);
    i_start = 1'b0;
    wait_to(k + 6);
    reset = 1'b1;
    @(negedge clk);
    check("r_en", o_enable, 0);
    check("r_busy", o_busy, 0);
    check("r_done", o_done, 0);
    check("r_cnt", o_tick_count, 0);
    reset = 1'b0;
    run_burst(4, 3);

    repeat (10) @(negedge clk);
    check("final_q", en_q.size() + done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
